pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_pkg.sv | 28 ++
 rtl/pc_hazard_det.sv | 34 +++
 rtl/pc_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings, limits and helpers for the PC / pipeline-register controller.
package pc_ctrl_pkg;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned WAIT_CNT_W = 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = 8'd255;

    typedef enum logic [1:0] {
        PcSrcSeq  = 2'b00,
        PcSrcJump = 2'b01,
        PcSrcBeq  = 2'b10,
        PcSrcJr   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StStall2 = 2'b01,
        StWait   = 2'b10
    } state_e;

    // True when a non-zero producer register feeds a used ID source operand.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rs,
                                       input logic uses_rt);
        return (dst != 5'd0) && ((uses_rs && dst == rs) || (uses_rt && dst == rt));
    endfunction

endpackage

// File: rtl/pc_hazard_det.sv
// Combinational hazard detection between the ID instruction and the EX/MEM producers.
module pc_hazard_det
    import pc_ctrl_pkg::*;
(
    input  logic       id_branch,
    input  logic       id_jr,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_dst,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] mem_dst,
    input  logic       mem_memread,
    output logic       lu_haz,
    output logic       br_ex_haz,
    output logic       br_mem_haz
);

    logic ex_match;
    logic mem_match;
    logic id_resolves;

    assign ex_match    = reg_match(ex_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign mem_match   = reg_match(mem_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    // Branches and jr resolve in ID, so they need operands one stage earlier.
    assign id_resolves = id_branch | id_jr;

    assign lu_haz     = ex_memread & ex_match;
    assign br_ex_haz  = id_resolves & ex_regwrite & ex_match;
    assign br_mem_haz = id_resolves & mem_memread & mem_match;

endmodule

// File: rtl/pc_ctrl.sv
// PC write/select and IF/ID, ID/EX control with stall FSM, fetch timeout and event counters.
module pc_ctrl
    import pc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic             id_branch,
    input  logic             id_br_taken,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_dst,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_dst,
    input  logic             mem_memread,
    input  logic             imem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic             fetch_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic lu_haz, br_ex_haz, br_mem_haz;
    logic stall, redirect, fetch_wait;

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    pc_hazard_det u_hazard_det (
        .id_branch   (id_branch),
        .id_jr       (id_jr),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_dst      (ex_dst),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .mem_dst     (mem_dst),
        .mem_memread (mem_memread),
        .lu_haz      (lu_haz),
        .br_ex_haz   (br_ex_haz),
        .br_mem_haz  (br_mem_haz)
    );

    assign stall      = (state_q == StStall2) | lu_haz | br_ex_haz | br_mem_haz;
    assign redirect   = ~stall & (id_jr | id_jump | (id_branch & id_br_taken));
    assign fetch_wait = ~stall & ~redirect & ~imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // A branch waiting on a load in EX needs the load to reach WB: two stall cycles.
    always_comb begin
        state_d = StRun;
        if (state_q == StStall2) begin
            state_d = StRun;
        end else if (br_ex_haz && ex_memread) begin
            state_d = StStall2;
        end else if (fetch_wait) begin
            state_d = StWait;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (fetch_wait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // The PC register itself is not reset, so hold it and flush IF/ID during reset.
    always_comb begin
        pc_write    = 1'b1;
        pc_src      = PcSrcSeq;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (redirect) begin
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            if (id_jr)        pc_src = PcSrcJr;
            else if (id_jump) pc_src = PcSrcJump;
            else              pc_src = PcSrcBeq;
        end else if (fetch_wait) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign state         = state_q;
    assign fetch_timeout = timeout_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_jump, id_jr, id_branch, id_br_taken;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt;
    logic [4:0]  ex_dst;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  mem_dst;
    logic        mem_memread;
    logic        imem_ready, cnt_clr;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  state;
    logic        fetch_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_jump       (id_jump),
        .id_jr         (id_jr),
        .id_branch     (id_branch),
        .id_br_taken   (id_br_taken),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_dst        (ex_dst),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread),
        .mem_dst       (mem_dst),
        .mem_memread   (mem_memread),
        .imem_ready    (imem_ready),
        .cnt_clr       (cnt_clr),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .state         (state),
        .fetch_timeout (fetch_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_jump = 0; id_jr = 0; id_branch = 0; id_br_taken = 0;
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_dst = 0; ex_regwrite = 0; ex_memread = 0;
        mem_dst = 0; mem_memread = 0; cnt_clr = 0;
    endtask

    initial begin
        clear_inputs();
        imem_ready = 1;
        rst_n = 0;
        #1;
        check("rst_pc_write", pc_write, 0);
        check("rst_ifid_write", ifid_write, 0);
        check("rst_ifid_flush", ifid_flush, 1);
        check("rst_bubble", idex_bubble, 0);
        check("rst_state", state, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_timeout", fetch_timeout, 0);
        tick();
        tick();
        rst_n = 1;
        #1;
        check("norm_pc_write", pc_write, 1);
        check("norm_ifid_write", ifid_write, 1);
        check("norm_pc_src", pc_src, 0);
        check("norm_flush", ifid_flush, 0);

        // Load-use: one stall cycle.
        ex_memread = 1; ex_regwrite = 1; ex_dst = 5; id_rs = 5; id_uses_rs = 1;
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_bubble", idex_bubble, 1);
        check("lu_ifid_write", ifid_write, 0);
        check("lu_flush", ifid_flush, 0);
        tick();
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0;
        #1;
        check("lu_after_pc_write", pc_write, 1);
        check("lu_after_bubble", idex_bubble, 0);
        check("lu_after_state", state, 0);
        check("lu_stall_cnt", stall_cnt, 1);

        // Branch on a load in EX: two stall cycles through STALL2.
        id_branch = 1; id_rs = 8; id_uses_rs = 1; ex_dst = 8; ex_memread = 1; ex_regwrite = 1;
        #1;
        check("brld_c1_pc_write", pc_write, 0);
        check("brld_c1_state", state, 0);
        tick();
        check("brld_c2_state", state, 1);
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0;
        #1;
        check("brld_c2_pc_write", pc_write, 0);
        check("brld_c2_bubble", idex_bubble, 1);
        tick();
        check("brld_c3_state", state, 0);
        check("brld_c3_pc_write", pc_write, 1);
        check("brld_stall_cnt", stall_cnt, 3);

        // Branch waiting on a load in MEM: one stall, no STALL2.
        id_rs = 0; id_uses_rs = 0; id_rt = 9; id_uses_rt = 1; mem_dst = 9; mem_memread = 1;
        #1;
        check("brmem_pc_write", pc_write, 0);
        tick();
        check("brmem_state", state, 0);
        check("brmem_stall_cnt", stall_cnt, 4);
        clear_inputs();

        // Redirects: jr beats jump, even while fetch is not ready.
        id_jr = 1; id_jump = 1; imem_ready = 0;
        #1;
        check("jr_pc_src", pc_src, 3);
        check("jr_pc_write", pc_write, 1);
        check("jr_flush", ifid_flush, 1);
        tick();
        check("jr_flush_cnt", flush_cnt, 1);
        check("jr_state", state, 0);
        id_jr = 0; id_jump = 0; id_branch = 1; id_br_taken = 1; imem_ready = 1;
        #1;
        check("beq_pc_src", pc_src, 2);
        check("beq_pc_write", pc_write, 1);
        tick();
        id_branch = 0; id_br_taken = 0; id_jump = 1;
        #1;
        check("jump_pc_src", pc_src, 1);
        tick();
        check("redir_flush_cnt", flush_cnt, 3);
        clear_inputs();

        // Destination register 0 never creates a hazard.
        ex_memread = 1; ex_regwrite = 1; ex_dst = 0; id_rs = 0; id_uses_rs = 1; id_branch = 1;
        #1;
        check("r0_pc_write", pc_write, 1);
        check("r0_bubble", idex_bubble, 0);
        tick();
        check("r0_stall_cnt", stall_cnt, 4);
        clear_inputs();

        // Fetch wait for 300 cycles; timeout after 255 consecutive waits.
        imem_ready = 0;
        #1;
        check("fw_pc_write", pc_write, 0);
        check("fw_flush", ifid_flush, 1);
        check("fw_ifid_write", ifid_write, 0);
        for (int i = 1; i <= 300; i++) begin
            tick();
            check("fw_state", state, 2);
            check("fw_loop_pc_write", pc_write, 0);
            check("fw_timeout", fetch_timeout, (i >= 255) ? 1 : 0);
        end
        imem_ready = 1;
        tick();
        check("fw_end_state", state, 0);
        check("fw_end_timeout", fetch_timeout, 1);
        check("fw_end_pc_write", pc_write, 1);

        // Stall counter saturation and clear priority.
        ex_memread = 1; ex_dst = 5; id_rs = 5; id_uses_rs = 1;
        repeat (65531) tick();
        check("sat_stall_cnt", stall_cnt, 16'hFFFF);
        tick();
        check("sat_hold_stall_cnt", stall_cnt, 16'hFFFF);
        cnt_clr = 1;
        tick();
        check("clr_stall_cnt", stall_cnt, 0);
        check("clr_flush_cnt", flush_cnt, 0);
        cnt_clr = 0;
        tick();
        check("post_clr_stall_cnt", stall_cnt, 1);
        clear_inputs();

        // Reset while in STALL2.
        id_branch = 1; id_rs = 8; id_uses_rs = 1; ex_dst = 8; ex_memread = 1; ex_regwrite = 1;
        tick();
        check("rs2_state", state, 1);
        #2;
        rst_n = 0;
        #1;
        check("rs2_rst_state", state, 0);
        check("rs2_rst_pc_write", pc_write, 0);
        check("rs2_rst_flush", ifid_flush, 1);
        check("rs2_rst_bubble", idex_bubble, 0);
        check("rs2_rst_ifid_write", ifid_write, 0);
        check("rs2_rst_stall_cnt", stall_cnt, 0);
        check("rs2_rst_timeout", fetch_timeout, 0);
        clear_inputs();
        tick();
        rst_n = 1;
        #1;
        check("rs2_rel_state", state, 0);
        check("rs2_rel_pc_write", pc_write, 1);
        tick();
        check("rs2_run_state", state, 0);
        check("rs2_run_pc_write", pc_write, 1);
        imem_ready = 0;
        #1;
        check("rs2_wait_pc_write", pc_write, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
